pc_stack_unit: RTL and testbench

Parametrised program-counter unit, successor to the datapath's 10-bit increment/load counter. It adds signed relative branches, hardware call/return through an internal return-address stack of configurable depth, and sticky overflow/underflow error reporting. It sits between the FSM (operation select, enable) and memory port A (instruction address), and takes absolute targets from the register-mux A output.

---
 rtl/pc_stack_if.sv | 31 +++
 rtl/pc_stack_unit.sv | 111 +++++++++++
 tb/tb_pc_stack_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_if.sv
// Control and address bundle between the sequencer FSM and the program-counter unit.
// The FSM side is the master; pc_stack_unit is the slave.
interface pc_stack_if #(
  parameter int ADDR_W      = 10,
  parameter int DISP_W      = 8,
  parameter int STACK_DEPTH = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               pc_en;
  logic [2:0]         op;
  logic [ADDR_W-1:0]  tgt_in;
  logic [DISP_W-1:0]  disp_in;
  logic               err_clr;
  logic [ADDR_W-1:0]  pc_out;
  logic [ADDR_W-1:0]  ret_addr;
  logic [DEPTH_W-1:0] depth;
  logic               stk_full;
  logic               stk_empty;
  logic [1:0]         stk_err;

  modport master (
    output pc_en, op, tgt_in, disp_in, err_clr,
    input  pc_out, ret_addr, depth, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  pc_en, op, tgt_in, disp_in, err_clr,
    output pc_out, ret_addr, depth, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with increment/load, signed relative branch and call/return
// through a LIFO return-address stack; overflow/underflow errors are sticky.
module pc_stack_unit #(
  parameter int                ADDR_W      = 10,
  parameter int                DISP_W      = 8,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input logic       clk,
  input logic       reset,
  pc_stack_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_INC    = 3'b000,
    OP_LOAD   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100
  } op_e;

  logic [ADDR_W-1:0]  pc_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [1:0]         err_q;
  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

  logic [ADDR_W-1:0]  pc_d;
  logic [DEPTH_W-1:0] depth_d;
  logic               push;
  logic               ovf;
  logic               unf;
  logic               full;
  logic               empty;
  logic [ADDR_W-1:0]  pc_inc;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;

  assign full   = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty  = (depth_q == '0);
  assign pc_inc = pc_q + ADDR_W'(1);
  // The next free slot is indexed by depth; the top entry sits one below it.
  assign wr_idx = depth_q[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    push    = 1'b0;
    ovf     = 1'b0;
    unf     = 1'b0;
    if (bus.pc_en) begin
      case (op_e'(bus.op))
        OP_INC:    pc_d = pc_inc;
        OP_LOAD:   pc_d = bus.tgt_in;
        OP_BRANCH: pc_d = pc_q + ADDR_W'($signed(bus.disp_in));
        OP_CALL: begin
          if (full) begin
            ovf = 1'b1;
          end else begin
            push    = 1'b1;
            pc_d    = bus.tgt_in;
            depth_d = depth_q + DEPTH_W'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            unf = 1'b1;
          end else begin
            pc_d    = stack_mem[rd_idx];
            depth_d = depth_q - DEPTH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      err_q   <= 2'b00;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      // A new error wins over a simultaneous clear of the same bit.
      err_q   <= (err_q & ~{2{bus.err_clr}}) | {unf, ovf};
    end
  end

  // NOTE: the stack array is deliberately not reset; depth alone marks which
  // entries are valid, so clearing the storage would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[wr_idx] <= pc_inc;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.ret_addr  = empty ? '0 : stack_mem[rd_idx];
  assign bus.depth     = depth_q;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.stk_err   = err_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed walk through the PC and stack
// behaviour, then randomized traffic against a queue-based reference model.
module tb_pc_stack_unit;
  localparam int ADDR_W      = 10;
  localparam int DISP_W      = 8;
  localparam int STACK_DEPTH = 8;
  localparam int ADDR_MOD    = 1 << ADDR_W;

  localparam logic [2:0] INC = 3'b000, LOAD = 3'b001, BRANCH = 3'b010,
                         CALL = 3'b011, RET = 3'b100, HOLD = 3'b110;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  int m_pc  = 0;
  int m_err = 0;
  int m_stk[$];

  pc_stack_if #(.ADDR_W(ADDR_W), .DISP_W(DISP_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

  pc_stack_unit #(
    .ADDR_W(ADDR_W), .DISP_W(DISP_W), .STACK_DEPTH(STACK_DEPTH), .RESET_ADDR('0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [2:0] o,
                            input int t, input int d, input logic clr);
    int new_err;
    int sd;
    new_err = 0;
    if (rst) begin
      m_pc  = 0;
      m_err = 0;
      m_stk.delete();
      return;
    end
    if (en) begin
      case (o)
        INC:    m_pc = (m_pc + 1) % ADDR_MOD;
        LOAD:   m_pc = t;
        BRANCH: begin
          sd   = (d >= 128) ? d - 256 : d;
          m_pc = (m_pc + sd + ADDR_MOD) % ADDR_MOD;
        end
        CALL: begin
          if (m_stk.size() == STACK_DEPTH) new_err = 1;
          else begin
            m_stk.push_back((m_pc + 1) % ADDR_MOD);
            m_pc = t;
          end
        end
        RET: begin
          if (m_stk.size() == 0) new_err = 2;
          else m_pc = m_stk.pop_back();
        end
        default: ;
      endcase
    end
    m_err = (clr ? 0 : m_err) | new_err;
  endtask

  task automatic check_model(input string tag);
    int exp_ret;
    exp_ret = (m_stk.size() == 0) ? 0 : m_stk[m_stk.size() - 1];
    check({tag, ".pc"},    32'(bus.pc_out),    32'(m_pc));
    check({tag, ".depth"}, 32'(bus.depth),     32'(m_stk.size()));
    check({tag, ".ret"},   32'(bus.ret_addr),  32'(exp_ret));
    check({tag, ".full"},  32'(bus.stk_full),  32'(m_stk.size() == STACK_DEPTH));
    check({tag, ".empty"}, 32'(bus.stk_empty), 32'(m_stk.size() == 0));
    check({tag, ".err"},   32'(bus.stk_err),   32'(m_err));
  endtask

  // Drive one cycle, advance the model on the edge, compare 1 time unit later.
  task automatic step(input string tag, input logic en, input logic [2:0] o,
                      input logic [9:0] t, input logic [7:0] d,
                      input logic clr = 1'b0, input logic rst = 1'b0);
    reset       = rst;
    bus.pc_en   = en;
    bus.op      = o;
    bus.tgt_in  = t;
    bus.disp_in = d;
    bus.err_clr = clr;
    @(posedge clk);
    model_step(rst, en, o, int'(t), int'(d), clr);
    #1;
    check_model(tag);
  endtask

  initial begin
    bus.pc_en = 1'b0; bus.op = HOLD; bus.tgt_in = '0; bus.disp_in = '0; bus.err_clr = 1'b0;
    #2;

    // Reset and increment / wrap
    step("reset", 1'b0, HOLD, 10'h0, 8'h0, 1'b0, 1'b1);
    check("reset.pc_const", 32'(bus.pc_out), 32'h0);
    check("reset.empty_const", 32'(bus.stk_empty), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      step("inc", 1'b1, INC, 10'h0, 8'h0);
      check("inc.const", 32'(bus.pc_out), 32'(i));
    end
    step("load3ff", 1'b1, LOAD, 10'h3FF, 8'h0);
    step("wrap", 1'b1, INC, 10'h0, 8'h0);
    check("wrap.const", 32'(bus.pc_out), 32'h000);

    // Relative branches
    step("load010", 1'b1, LOAD, 10'h010, 8'h0);
    step("br_m4", 1'b1, BRANCH, 10'h0, 8'hFC);
    check("br_m4.const", 32'(bus.pc_out), 32'h00C);
    step("br_7f", 1'b1, BRANCH, 10'h0, 8'h7F);
    check("br_7f.const", 32'(bus.pc_out), 32'h08B);
    step("load002", 1'b1, LOAD, 10'h002, 8'h0);
    step("br_wrap", 1'b1, BRANCH, 10'h0, 8'hFC);
    check("br_wrap.const", 32'(bus.pc_out), 32'h3FE);
    check("br_wrap.err", 32'(bus.stk_err), 32'h0);

    // Nested call / return
    step("load020", 1'b1, LOAD, 10'h020, 8'h0);
    step("call100", 1'b1, CALL, 10'h100, 8'h0);
    check("call100.ret_const", 32'(bus.ret_addr), 32'h021);
    step("call200", 1'b1, CALL, 10'h200, 8'h0);
    check("call200.ret_const", 32'(bus.ret_addr), 32'h101);
    step("ret1", 1'b1, RET, 10'h0, 8'h0);
    check("ret1.const", 32'(bus.pc_out), 32'h101);
    step("ret2", 1'b1, RET, 10'h0, 8'h0);
    check("ret2.const", 32'(bus.pc_out), 32'h021);

    // Fill, overflow, unwind, underflow
    for (int i = 0; i < STACK_DEPTH; i++) step("fill", 1'b1, CALL, 10'(32'h040 + i * 16), 8'h0);
    check("fill.full_const", 32'(bus.stk_full), 32'h1);
    step("ovf", 1'b1, CALL, 10'h3A0, 8'h0);
    check("ovf.pc_const", 32'(bus.pc_out), 32'h0B0);
    check("ovf.err_const", 32'(bus.stk_err), 32'h1);
    for (int i = 0; i < STACK_DEPTH; i++) step("unwind", 1'b1, RET, 10'h0, 8'h0);
    check("unwind.pc_const", 32'(bus.pc_out), 32'h022);
    step("unf", 1'b1, RET, 10'h0, 8'h0);
    check("unf.err_const", 32'(bus.stk_err), 32'h3);
    step("clr_all", 1'b0, HOLD, 10'h0, 8'h0, 1'b1);

    // err_clr racing a new error, then pc_en gating
    for (int i = 0; i <= STACK_DEPTH; i++) step("refill", 1'b1, CALL, 10'h300, 8'h0);
    for (int i = 0; i < STACK_DEPTH; i++) step("drain", 1'b1, RET, 10'h0, 8'h0);
    check("drain.err_const", 32'(bus.stk_err), 32'h1);
    step("clr_race", 1'b1, RET, 10'h0, 8'h0, 1'b1);
    check("clr_race.err_const", 32'(bus.stk_err), 32'h2);
    step("clr_only", 1'b0, RET, 10'h0, 8'h0, 1'b1);
    check("clr_only.err_const", 32'(bus.stk_err), 32'h0);
    step("gated_call", 1'b0, CALL, 10'h155, 8'h0);
    step("gated_inc", 1'b0, INC, 10'h0, 8'h0);
    step("hold_code", 1'b1, 3'b111, 10'h2AA, 8'h55);

    // Reset mid-sequence overrides a CALL
    for (int i = 0; i < 5; i++) step("depth5", 1'b1, CALL, 10'(32'h200 + i), 8'h0);
    check("depth5.const", 32'(bus.depth), 32'h5);
    step("mid_reset", 1'b1, CALL, 10'h1FF, 8'h0, 1'b0, 1'b1);
    check("mid_reset.depth_const", 32'(bus.depth), 32'h0);
    check("mid_reset.ret_const", 32'(bus.ret_addr), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [2:0] r_op;
      r_op = ($urandom_range(0, 9) < 6) ? 3'($urandom_range(3, 4)) : 3'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 9) != 0), r_op, 10'($urandom), 8'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
